// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Shares one external combinational ALU between two requesters.
//               Valid/ready request ports, registered ALU operands, and a single
//               response channel tagged with the owning requester id.
//               Optional build macro: ALU_ARB_FIXED_PRIO_EN (requester 0 always
//               wins a tie; otherwise round-robin).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*OP_W-1:0]   req_opcode,
  input  logic [2*OP_W-1:0]   req_funct,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  output logic [OP_W-1:0]     alu_opcode,
  output logic [OP_W-1:0]     alu_funct,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  input  logic [DATA_W-1:0]   alu_ans,
  input  logic                alu_zflag,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_zflag,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic   r_owner;     // requester whose operation is in flight
  logic   w_any;
  logic   w_accept;
  logic   w_grant;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic   r_rr_last;   // requester granted most recently
`endif

  // Arbitration: pick a winner and decide whether it is accepted this cycle
  always_comb begin
    w_any    = |req_valid;
    w_accept = w_any && ((r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready));
`ifdef ALU_ARB_FIXED_PRIO_EN
    // Requester 0 wins whenever it is asking
    w_grant  = ~req_valid[0];
`else
    // On a tie the requester not served last goes first
    w_grant  = (&req_valid) ? ~r_rr_last : req_valid[1];
`endif
    req_ready = 2'b00;
    if (w_accept) begin
      req_ready = w_grant ? 2'b10 : 2'b01;
    end
  end

  // Next-state logic for the IDLE -> EXEC -> RESP sequence
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_EXEC;
      S_EXEC: w_state_nxt = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = w_accept ? S_EXEC : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand registers: loaded only on accept so the ALU inputs stay quiet otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_opcode <= '0;
      alu_funct  <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      r_owner    <= 1'b0;
    end else if (w_accept) begin
      alu_opcode <= w_grant ? req_opcode[OP_W +: OP_W]     : req_opcode[0 +: OP_W];
      alu_funct  <= w_grant ? req_funct[OP_W +: OP_W]      : req_funct[0 +: OP_W];
      alu_a      <= w_grant ? req_a[DATA_W +: DATA_W]      : req_a[0 +: DATA_W];
      alu_b      <= w_grant ? req_b[DATA_W +: DATA_W]      : req_b[0 +: DATA_W];
      r_owner    <= w_grant;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Round-robin history; reset value lets requester 0 win the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_last <= 1'b1;
    end else if (w_accept) begin
      r_rr_last <= w_grant;
    end
  end
`endif

  // Response capture at the end of the EXEC cycle; held through RESP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_data  <= '0;
      rsp_zflag <= 1'b0;
      rsp_id    <= 1'b0;
    end else if (r_state == S_EXEC) begin
      rsp_data  <= alu_ans;
      rsp_zflag <= alu_zflag;
      rsp_id    <= r_owner;
    end
  end

  // Status outputs decoded from the state register
  always_comb begin
    rsp_valid = (r_state == S_RESP);
    busy      = (r_state != S_IDLE);
  end

endmodule
`default_nettype wire
